// File: rtl/fault_test_pkg.sv
// Shared definitions for the stuck-at fault test sequencer: FSM state
// encoding and a helper that turns an input width into a vector count.
package fault_test_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_DONE
   } state_t;

   // Number of distinct vectors an n_in-bit CUT input can take.
   function automatic int vec_count(input int n_in);
      return 1 << n_in;
   endfunction

   localparam int DEFAULT_N_IN      = 3;
   localparam int DEFAULT_VEC_COUNT = vec_count(DEFAULT_N_IN);

endpackage

// File: rtl/fault_test_sequencer_settle_timer.sv
// settle_timer: loadable down-counter that tells the sequencer when the
// current vector has been held long enough for both CUTs to settle.
module settle_timer #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] count_reg;

   // Load has priority; decrement stops at zero so the count never wraps.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_value;
      end else if (dec && (count_reg != '0)) begin
         count_reg <= count_reg - WIDTH'(1);
      end
   end

   assign zero = (count_reg == '0);

endmodule

// File: rtl/fault_test_sequencer.sv
// fault_test_sequencer: applies every input vector to a fault-free and a
// faulty CUT copy, waits a settle window, compares their outputs and
// records which vectors detect the fault.
// Optional build macro STOP_ON_FIRST_DETECT_EN: end the run at the first
// detecting vector instead of applying all vectors.
module fault_test_sequencer
   import fault_test_pkg::*;
#(
   parameter int N_IN          = 3,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic [N_IN-1:0]      vec,
   input  logic                 f0,
   input  logic                 f1,
   output logic                 busy,
   output logic                 done,
   output logic [(1<<N_IN)-1:0] detect_mask,
   output logic [N_IN:0]        detect_count,
   output logic [N_IN-1:0]      first_vec,
   output logic                 first_valid
);

   localparam int NVEC = vec_count(N_IN);
   localparam int TW   = $clog2(SETTLE_CYCLES) + 1;
   localparam logic [TW-1:0]   SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
   localparam logic [N_IN-1:0] LAST_VEC    = '1;

   state_t            state_reg, state_next;
   logic [N_IN-1:0]   vec_reg;
   logic              busy_reg, done_reg;
   logic [NVEC-1:0]   mask_reg;
   logic [N_IN:0]     count_reg;
   logic [N_IN-1:0]   first_vec_reg;
   logic              first_valid_reg;

   logic              timer_load, timer_dec, timer_zero;
   logic              start_accept;
   logic              hit;
   logic              finish_run;

   // Only the SAMPLE state ever looks at this, so SETTLE glitches are harmless.
   assign hit = f0 ^ f1;

`ifdef STOP_ON_FIRST_DETECT_EN
   assign finish_run = (vec_reg == LAST_VEC) || hit;
`else
   assign finish_run = (vec_reg == LAST_VEC);
`endif

   settle_timer #(.WIDTH(TW)) u_settle_timer (
      .clk        (clk),
      .rst        (rst),
      .load       (timer_load),
      .load_value (SETTLE_LOAD),
      .dec        (timer_dec),
      .zero       (timer_zero)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_reg <= ST_IDLE;
      else     state_reg <= state_next;
   end

   // Next-state and timer control. busy_reg still being high in IDLE marks
   // the done-pulse cycle, during which a start must not be accepted.
   always_comb begin
      state_next   = state_reg;
      timer_load   = 1'b0;
      timer_dec    = 1'b0;
      start_accept = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start && !busy_reg) begin
               start_accept = 1'b1;
               timer_load   = 1'b1;
               state_next   = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (timer_zero) state_next = ST_SAMPLE;
            else            timer_dec  = 1'b1;
         end
         ST_SAMPLE: begin
            if (finish_run) begin
               state_next = ST_DONE;
            end else begin
               timer_load = 1'b1;
               state_next = ST_SETTLE;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Vector counter, handshake flags and detection results.
   always_ff @(posedge clk) begin
      if (rst) begin
         vec_reg         <= '0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
         mask_reg        <= '0;
         count_reg       <= '0;
         first_vec_reg   <= '0;
         first_valid_reg <= 1'b0;
      end else begin
         done_reg <= (state_reg == ST_DONE);
         if (done_reg) busy_reg <= 1'b0;
         if (start_accept) begin
            busy_reg        <= 1'b1;
            vec_reg         <= '0;
            mask_reg        <= '0;
            count_reg       <= '0;
            first_vec_reg   <= '0;
            first_valid_reg <= 1'b0;
         end
         if (state_reg == ST_SAMPLE) begin
            if (hit) begin
               mask_reg[vec_reg] <= 1'b1;
               count_reg         <= count_reg + (N_IN+1)'(1);
               if (!first_valid_reg) begin
                  first_vec_reg   <= vec_reg;
                  first_valid_reg <= 1'b1;
               end
            end
            if (!finish_run) vec_reg <= vec_reg + N_IN'(1);
         end
      end
   end

   assign vec          = vec_reg;
   assign busy         = busy_reg;
   assign done         = done_reg;
   assign detect_mask  = mask_reg;
   assign detect_count = count_reg;
   assign first_vec    = first_vec_reg;
   assign first_valid  = first_valid_reg;

endmodule

// File: tb/tb_fault_test_sequencer.sv
// Bench for fault_test_sequencer: a timing/result model derived from the
// vector schedule is compared against the DUT every cycle, plus literal
// checks for the headline scenarios.
module tb_fault_test_sequencer;

   localparam int N_IN = 3;
   localparam int S    = 2;
   localparam int NV   = 1 << N_IN;
   localparam int P    = S + 1;

   typedef struct packed {
      logic [N_IN-1:0] vec;
      logic            busy;
      logic            done;
      logic [NV-1:0]   mask;
      logic [N_IN:0]   count;
      logic [N_IN-1:0] first;
      logic            fvalid;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [N_IN-1:0] vec;
   logic            f0, f1;
   logic            busy, done;
   logic [NV-1:0]   detect_mask;
   logic [N_IN:0]   detect_count;
   logic [N_IN-1:0] first_vec;
   logic            first_valid;

   logic [NV-1:0]   fault_map = '0;
   logic            glitch = 1'b0;
   bit              glitch_en = 1'b0;
   bit              chk_en = 1'b0;

   // Model state: mode 0 = nothing since reset, 1 = run started c edges ago
   int              mode = 0;
   int              c = 0;
   logic [NV-1:0]   run_map = '0;

   int              n_cmp = 0;
   int              n_fail = 0;

   always #5 clk = ~clk;

   // CUT pair: f0 is vector parity, f1 differs wherever the fault map says.
   assign f0 = ^vec;
   assign f1 = f0 ^ fault_map[vec] ^ glitch;

   fault_test_sequencer #(.N_IN(N_IN), .SETTLE_CYCLES(S)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .vec          (vec),
      .f0           (f0),
      .f1           (f1),
      .busy         (busy),
      .done         (done),
      .detect_mask  (detect_mask),
      .detect_count (detect_count),
      .first_vec    (first_vec),
      .first_valid  (first_valid)
   );

   function automatic int last_applied(input logic [NV-1:0] m);
`ifdef STOP_ON_FIRST_DETECT_EN
      for (int v = 0; v < NV; v++) if (m[v]) return v;
`endif
      return NV - 1;
   endfunction

   function automatic int done_cycle(input logic [NV-1:0] m);
      return (last_applied(m) + 1) * P + 1;
   endfunction

   function automatic exp_t model(input int md, input int cc, input logic [NV-1:0] m);
      exp_t e;
      int   la;
      int   d;
      e = '0;
      if (md == 1) begin
         la = last_applied(m);
         d  = done_cycle(m);
         e.vec  = N_IN'((cc / P > la) ? la : cc / P);
         e.busy = (cc <= d);
         e.done = (cc == d);
         for (int v = 0; v <= la; v++) begin
            if (m[v] && cc >= P * v + P) begin
               e.mask[v] = 1'b1;
               e.count   = e.count + 1'b1;
               if (!e.fvalid) begin
                  e.fvalid = 1'b1;
                  e.first  = N_IN'(v);
               end
            end
         end
      end
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model bookkeeping: reset, start acceptance, cycle count.
   always @(posedge clk) begin
      if (rst) begin
         mode <= 0;
         c    <= 0;
      end else if (start && !(mode == 1 && c <= done_cycle(run_map))) begin
         mode    <= 1;
         c       <= 0;
         run_map <= fault_map;
      end else if (mode == 1 && c < 100000) begin
         c <= c + 1;
      end
   end

   // Optional glitching of f1, kept quiet in every SAMPLE cycle.
   always @(posedge clk) begin
      #2;
      if (glitch_en && !(mode == 1 && (c % P) == S)) glitch = 1'($urandom_range(0, 1));
      else                                           glitch = 1'b0;
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      exp_t e;
      if (chk_en) begin
         e = model(mode, c, run_map);
         check("vec",          32'(vec),          32'(e.vec));
         check("busy",         32'(busy),         32'(e.busy));
         check("done",         32'(done),         32'(e.done));
         check("detect_mask",  32'(detect_mask),  32'(e.mask));
         check("detect_count", 32'(detect_count), 32'(e.count));
         check("first_vec",    32'(first_vec),    32'(e.first));
         check("first_valid",  32'(first_valid),  32'(e.fvalid));
      end
   end

   task automatic do_run(input logic [NV-1:0] map, input bit glitchy, input bit pulses,
                         output int done_at, output int n_done);
      bit finished;
      fault_map = map;
      glitch_en = glitchy;
      start = 1'b1;
      tick();
      start = 1'b0;
      done_at  = -1;
      n_done   = 0;
      finished = 1'b0;
      for (int i = 0; i < 200 && !finished; i++) begin
         if (done === 1'b1) begin
            n_done++;
            if (done_at < 0) done_at = c;
         end
         if (done_at >= 0 && c >= done_at + 3) finished = 1'b1;
         else begin
            start = pulses && (c == 5 || c == 12 || done === 1'b1);
            tick();
         end
      end
      start = 1'b0;
      glitch_en = 1'b0;
      if (!finished) check("run_timeout", 32'(done_at), 32'hFFFF_FFFF);
      $display("run map=%02h glitch=%0d pulses=%0d done_at=%0d dones=%0d mask=%02h count=%0d first=%0d/%0d",
               map, glitchy, pulses, done_at, n_done, detect_mask, detect_count, first_vec, first_valid);
   endtask

   initial begin
      int done_at, n_done;
      bit ok;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      chk_en = 1'b1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_mask", 32'(detect_mask), 32'd0);

      // Fault-free CUT pair
      do_run(8'h00, 1'b0, 1'b0, done_at, n_done);
      check("nofault_done_at", 32'(done_at), 32'd25);
      check("nofault_mask", 32'(detect_mask), 32'h00);
      check("nofault_count", 32'(detect_count), 32'd0);
      check("nofault_fvalid", 32'(first_valid), 32'd0);

      // Detections at vectors 2 and 6, with start pulses that must be ignored
      do_run(8'b0100_0100, 1'b0, 1'b1, done_at, n_done);
      check("two_ndone", 32'(n_done), 32'd1);
`ifdef STOP_ON_FIRST_DETECT_EN
      check("two_done_at", 32'(done_at), 32'd10);
      check("two_mask", 32'(detect_mask), 32'b0000_0100);
      check("two_count", 32'(detect_count), 32'd1);
`else
      check("two_done_at", 32'(done_at), 32'd25);
      check("two_mask", 32'(detect_mask), 32'b0100_0100);
      check("two_count", 32'(detect_count), 32'd2);
`endif
      check("two_first", 32'(first_vec), 32'd2);
      check("two_fvalid", 32'(first_valid), 32'd1);

      // Differences only during SETTLE
      do_run(8'h00, 1'b1, 1'b0, done_at, n_done);
      check("glitch_mask", 32'(detect_mask), 32'h00);

      // Reset in the middle of a run at vector 4
      fault_map = 8'h00;
      start = 1'b1;
      tick();
      start = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (c == 4 * P) ok = 1'b1;
         else tick();
      end
      check("midrun_vec", 32'(vec), 32'd4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_vec", 32'(vec), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_count", 32'(detect_count), 32'd0);
      check("rst_fvalid", 32'(first_valid), 32'd0);
      tick();
      do_run(8'b0100_0100, 1'b0, 1'b0, done_at, n_done);
      check("post_rst_first", 32'(first_vec), 32'd2);
      check("post_rst_ndone", 32'(n_done), 32'd1);

      // Random fault maps, glitching and start pulses
      for (int r = 0; r < 12; r++) begin
         do_run(NV'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), done_at, n_done);
         check("rand_ndone", 32'(n_done), 32'd1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
